// File: rtl/lsu_align_ctrl.sv
// Load/store alignment controller: maps byte-addressed core accesses onto a
// word-addressed memory, splitting word-crossing accesses into two cycles.
module lsu_align_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int WADDR_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic               req_write,
  input  logic [2:0]         funct3,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [31:0]        wdata,
  output logic               stall,
  output logic               done,
  output logic               err,
  output logic [31:0]        rdata,
  output logic [WADDR_W-1:0] mem_addr,
  output logic               mem_re,
  output logic               mem_we,
  output logic [3:0]         mem_be,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

  state_t              state_q, state_d;
  logic                write_q, write_d;
  logic [2:0]          f3_q, f3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         lo_q, lo_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [1:0]          off;
  logic [2:0]          size;
  logic [3:0]          ones;
  logic                spans;
  logic [7:0]          m8;
  logic [63:0]         w64;
  logic [WADDR_W-1:0]  word0, word1;
  logic [31:0]         lo_sel, hi_sel, r, load_val;
  logic                req_illegal;

  // Lane geometry of the latched request.
  always_comb begin
    off = addr_q[1:0];
    case (f3_q[1:0])
      2'b00:   begin size = 3'd1; ones = 4'b0001; end
      2'b01:   begin size = 3'd2; ones = 4'b0011; end
      default: begin size = 3'd4; ones = 4'b1111; end
    endcase
    spans = ({1'b0, off} + size) > 3'd4;
    m8    = {4'b0000, ones} << off;
    w64   = {32'h0, wdata_q} << {off, 3'b000};
    word0 = WADDR_W'(addr_q[ADDR_W-1:2]);
    word1 = word0 + WADDR_W'(1);
  end

  assign req_illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) ||
                       (req_write && funct3[2]);

  // In ACC1 the low word was captured last cycle; otherwise it is on the bus now.
  always_comb begin
    lo_sel = (state_q == ACC1) ? lo_q : mem_rdata;
    hi_sel = (state_q == ACC1) ? mem_rdata : 32'h0;
    r      = 32'({hi_sel, lo_sel} >> {off, 3'b000});
    case (f3_q)
      3'b000:  load_val = {{24{r[7]}}, r[7:0]};
      3'b001:  load_val = {{16{r[15]}}, r[15:0]};
      3'b100:  load_val = {24'h0, r[7:0]};
      3'b101:  load_val = {16'h0, r[15:0]};
      default: load_val = r;
    endcase
  end

  // Strobes are gated by rst so they drop before the reset edge lands.
  always_comb begin
    mem_addr  = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_wdata = 32'h0;
    if (!rst) begin
      case (state_q)
        ACC0: begin
          mem_addr  = word0;
          mem_be    = m8[3:0];
          mem_re    = !write_q;
          mem_we    = write_q;
          mem_wdata = write_q ? w64[31:0] : 32'h0;
        end
        ACC1: begin
          mem_addr  = word1;
          mem_be    = m8[7:4];
          mem_re    = !write_q;
          mem_we    = write_q;
          mem_wdata = write_q ? w64[63:32] : 32'h0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    lo_d    = lo_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          f3_d    = funct3;
          addr_d  = addr;
          wdata_d = wdata;
          if (req_illegal) begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end else begin
            state_d = ACC0;
          end
        end
      end
      ACC0: begin
        if (!write_q) lo_d = mem_rdata;
        if (spans) begin
          state_d = ACC1;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
          rdata_d = write_q ? 32'h0 : load_val;
        end
      end
      ACC1: begin
        state_d = DONE;
        done_d  = 1'b1;
        rdata_d = write_q ? 32'h0 : load_val;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      lo_q    <= 32'h0;
      rdata_q <= 32'h0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign done  = done_q;
  assign err   = err_q;
  assign rdata = rdata_q;
  assign stall = req_valid && !done_q;

endmodule
